// File: rtl/video_crop.sv
// video_crop: cuts a rectangular window out of an AXI4-Stream video stream
// (tuser = start of frame, tlast = end of line). The window and the enable are
// captured on every start-of-frame beat, so software may rewrite them at any time.
// Handshake: a beat transfers on tvalid & tready. One registered output stage;
// video_i_tready = !video_o_tvalid | video_o_tready. Dropped beats are consumed
// without output. The output holds steady while tvalid & !tready.
module video_crop #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [CNT_WIDTH-1:0]  x_start_i,
    input  logic [CNT_WIDTH-1:0]  x_size_i,
    input  logic [CNT_WIDTH-1:0]  y_start_i,
    input  logic [CNT_WIDTH-1:0]  y_size_i,
    input  logic [DATA_WIDTH-1:0] video_i_tdata,
    input  logic                  video_i_tvalid,
    input  logic                  video_i_tuser,
    input  logic                  video_i_tlast,
    output logic                  video_i_tready,
    output logic [DATA_WIDTH-1:0] video_o_tdata,
    output logic                  video_o_tvalid,
    output logic                  video_o_tuser,
    output logic                  video_o_tlast,
    input  logic                  video_o_tready,
    output logic                  dbg_state_o
);

    typedef enum logic {S_WAIT_SOF = 1'b0, S_ACTIVE = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   END_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_en;
    logic [CNT_WIDTH-1:0]    r_xs, r_xsz, r_ys, r_ysz;
    logic [CNT_WIDTH-1:0]    r_px, r_ln;
    logic [DATA_WIDTH-1:0]   r_o_tdata;
    logic                    r_o_tvalid, r_o_tuser, r_o_tlast;

    logic                    w_accept, w_sof, w_live, w_keep, w_fwd;
    logic                    w_en, w_out_user, w_out_last;
    logic [CNT_WIDTH-1:0]    w_xs, w_xsz, w_ys, w_ysz, w_px, w_ln;
    logic [CNT_WIDTH-1:0]    w_px_inc, w_ln_inc;
    logic [CNT_WIDTH:0]      w_x_end, w_y_end;

    assign video_i_tready = !r_o_tvalid | video_o_tready;
    assign w_accept       = video_i_tvalid & video_i_tready;
    assign w_sof          = video_i_tuser;

    // A start-of-frame beat is judged against the config arriving with it and sits at px 0 / ln 0.
    assign w_en  = w_sof ? en_i      : r_en;
    assign w_xs  = w_sof ? x_start_i : r_xs;
    assign w_xsz = w_sof ? x_size_i  : r_xsz;
    assign w_ys  = w_sof ? y_start_i : r_ys;
    assign w_ysz = w_sof ? y_size_i  : r_ysz;
    assign w_px  = w_sof ? '0        : r_px;
    assign w_ln  = w_sof ? '0        : r_ln;

    // One extra bit keeps start+size from overflowing.
    assign w_x_end = {1'b0, w_xs} + {1'b0, w_xsz};
    assign w_y_end = {1'b0, w_ys} + {1'b0, w_ysz};
    assign w_keep  = (w_px >= w_xs) && ({1'b0, w_px} < w_x_end) &&
                     (w_ln >= w_ys) && ({1'b0, w_ln} < w_y_end);

    assign w_live     = (r_state == S_ACTIVE) | w_sof;
    assign w_fwd      = w_live & (!w_en | w_keep);
    assign w_out_user = w_en ? (w_keep && (w_px == w_xs) && (w_ln == w_ys)) : video_i_tuser;
    assign w_out_last = w_en ? (w_keep && (({1'b0, w_px} == (w_x_end - END_ONE)) || video_i_tlast))
                             : video_i_tlast;

    assign w_px_inc = (w_px == CNT_MAX) ? w_px : w_px + CNT_ONE;
    assign w_ln_inc = (w_ln == CNT_MAX) ? w_ln : w_ln + CNT_ONE;

    assign video_o_tdata  = r_o_tdata;
    assign video_o_tvalid = r_o_tvalid;
    assign video_o_tuser  = r_o_tuser;
    assign video_o_tlast  = r_o_tlast;
    assign dbg_state_o    = (r_state == S_ACTIVE);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_WAIT_SOF;
        else          r_state <= w_state_nxt;
    end

    // Next state: any accepted SOF enters (or restarts) the active frame.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_sof) w_state_nxt = S_ACTIVE;
    end

    // Capture window config on each accepted SOF beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en  <= 1'b0;
            r_xs  <= '0;
            r_xsz <= '0;
            r_ys  <= '0;
            r_ysz <= '0;
        end else if (w_accept && w_sof) begin
            r_en  <= en_i;
            r_xs  <= x_start_i;
            r_xsz <= x_size_i;
            r_ys  <= y_start_i;
            r_ysz <= y_size_i;
        end
    end

    // Position of the next beat: tlast starts a new line, counters saturate.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_px <= '0;
            r_ln <= '0;
        end else if (w_accept && w_live) begin
            if (video_i_tlast) begin
                r_px <= '0;
                r_ln <= w_ln_inc;
            end else begin
                r_px <= w_px_inc;
                r_ln <= w_ln;
            end
        end
    end

    // Output register: load kept beats, clear valid once the sink has taken the beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_o_tvalid <= 1'b0;
            r_o_tdata  <= '0;
            r_o_tuser  <= 1'b0;
            r_o_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_o_tvalid <= w_fwd;
            if (w_fwd) begin
                r_o_tdata <= video_i_tdata;
                r_o_tuser <= w_out_user;
                r_o_tlast <= w_out_last;
            end
        end else if (video_o_tready) begin
            r_o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_crop.sv
// Directed bench for video_crop. Pixel data encodes {frame tag, line, pixel}
// so every expected output beat can be written down by hand.
module tb_video_crop;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b0;
  logic [11:0] cfg_xs = '0, cfg_xsz = '0, cfg_ys = '0, cfg_ysz = '0;
  logic [15:0] i_tdata = '0;
  logic        i_tvalid = 1'b0, i_tuser = 1'b0, i_tlast = 1'b0;
  logic        i_tready;
  logic [15:0] o_tdata;
  logic        o_tvalid, o_tuser, o_tlast;
  logic        o_tready = 1'b1;
  logic        dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 0;     // 0: always ready, 1: random, 2: never ready
  int          use_gaps = 0;
  int          stall_cnt = 0;
  int          stab_viol = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out = '0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  video_crop #(.DATA_WIDTH(16), .CNT_WIDTH(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(cfg_en),
    .x_start_i(cfg_xs), .x_size_i(cfg_xsz), .y_start_i(cfg_ys), .y_size_i(cfg_ysz),
    .video_i_tdata(i_tdata), .video_i_tvalid(i_tvalid), .video_i_tuser(i_tuser),
    .video_i_tlast(i_tlast), .video_i_tready(i_tready),
    .video_o_tdata(o_tdata), .video_o_tvalid(o_tvalid), .video_o_tuser(o_tuser),
    .video_o_tlast(o_tlast), .video_o_tready(o_tready), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // sink ready pattern, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      o_tready = ($urandom_range(0, 1) == 1);
    else if (rdy_mode == 2) o_tready = 1'b0;
    else                    o_tready = 1'b1;
  end

  // monitor: capture transfers and watch output stability while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!o_tvalid || {o_tuser, o_tlast, o_tdata} != prev_out))
        stab_viol = stab_viol + 1;
      if (o_tvalid && o_tready) got_q.push_back({o_tuser, o_tlast, o_tdata});
      prev_stall = o_tvalid && !o_tready;
      prev_out   = {o_tuser, o_tlast, o_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [17:0] mk(input int tag, input int ln, input int px,
                                     input bit u, input bit l);
    logic [3:0] t4, l4;
    logic [7:0] p8;
    t4 = tag[3:0];
    l4 = ln[3:0];
    p8 = px[7:0];
    return {u, l, t4, l4, p8};
  endfunction

  // driver tasks
  task automatic send_beat(input int tag, input int ln, input int px,
                           input bit u, input bit l);
    logic [17:0] b;
    bit done;
    if (use_gaps != 0 && $urandom_range(0, 2) == 0) begin
      i_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    b = mk(tag, ln, px, u, l);
    i_tdata  = b[15:0];
    i_tuser  = u;
    i_tlast  = l;
    i_tvalid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (i_tready) done = 1'b1;
      else stall_cnt = stall_cnt + 1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: beat tag %0d ln %0d px %0d never accepted", tag, ln, px);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int tag, input int w, input int h, input bit sof);
    for (int l = 0; l < h; l++)
      for (int p = 0; p < w; p++)
        send_beat(tag, l, p, sof && l == 0 && p == 0, p == w - 1);
    i_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_cfg(input bit e, input int xs, input int xsz, input int ys, input int ysz);
    cfg_en = e; cfg_xs = xs[11:0]; cfg_xsz = xsz[11:0]; cfg_ys = ys[11:0]; cfg_ysz = ysz[11:0];
  endtask

  // expected window of the 8x4 reference frame, window x 2/3, y 1/2
  task automatic push_case1(input int tag);
    for (int l = 1; l <= 2; l++)
      for (int p = 2; p <= 4; p++)
        exp_q.push_back(mk(tag, l, p, l == 1 && p == 2, p == 4));
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({o_tvalid, o_tuser, o_tlast, o_tdata} !== 19'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {o_tvalid, o_tuser, o_tlast, o_tdata});
    end
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got %b want 0", dbg_state);
    end
    n_cmp++;
    if (i_tready !== 1'b1) begin
      n_err++; $display("FAIL reset_tready: got %b want 1", i_tready);
    end
  endtask

  task automatic test_crop();
    got_q.delete(); exp_q.delete();
    set_cfg(1, 2, 3, 1, 2);
    send_frame(1, 8, 4, 1);
    idle(5);
    push_case1(1);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL crop_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL crop_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bypass();
    got_q.delete(); exp_q.delete();
    set_cfg(0, 2, 3, 1, 2);
    send_frame(2, 8, 4, 1);
    idle(5);
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 8; p++)
        exp_q.push_back(mk(2, l, p, l == 0 && p == 0, p == 7));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bypass_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bypass_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    got_q.delete(); exp_q.delete();
    stab_viol = 0;
    set_cfg(1, 2, 3, 1, 2);
    rdy_mode = 1; use_gaps = 1;
    send_frame(3, 8, 4, 1);
    send_frame(4, 8, 4, 1);
    use_gaps = 0;
    idle(10);
    rdy_mode = 0;
    idle(5);
    push_case1(3);
    push_case1(4);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stab_viol != 0) begin
      n_err++; $display("FAIL stall_stability: got %0d changes while stalled want 0", stab_viol);
    end
  endtask

  task automatic test_pre_sof();
    got_q.delete(); exp_q.delete();
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
    set_cfg(0, 0, 8, 0, 4);            // bypass config is ignored until a SOF arrives
    send_frame(5, 8, 2, 0);
    idle(3);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL presof_count: got %0d want 0", got_q.size());
    end
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_err++; $display("FAIL presof_state: got %b want 0", dbg_state);
    end
    got_q.delete();
    set_cfg(1, 2, 3, 1, 2);
    send_frame(6, 8, 4, 1);
    idle(5);
    push_case1(6);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL presof_win_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL presof_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_edge_window();
    got_q.delete(); exp_q.delete();
    set_cfg(1, 6, 5, 0, 4);
    send_frame(7, 8, 4, 1);
    idle(5);
    for (int l = 0; l < 4; l++)
      for (int p = 6; p <= 7; p++)
        exp_q.push_back(mk(7, l, p, l == 0 && p == 6, p == 7));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL edge_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL edge_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    // empty window with a blocked sink: nothing comes out, so input never stalls
    got_q.delete();
    set_cfg(1, 2, 0, 1, 2);
    rdy_mode = 2;
    idle(2);
    stall_cnt = 0;
    send_frame(8, 8, 4, 1);
    idle(2);
    n_cmp++;
    if (stall_cnt != 0) begin
      n_err++; $display("FAIL zero_size_stall: got %0d stall cycles want 0", stall_cnt);
    end
    n_cmp++;
    if (o_tvalid !== 1'b0) begin
      n_err++; $display("FAIL zero_size_valid: got %b want 0", o_tvalid);
    end
    rdy_mode = 0;
    idle(3);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL zero_size_count: got %0d want 0", got_q.size());
    end
  endtask

  task automatic test_mid_frame_cfg();
    got_q.delete(); exp_q.delete();
    set_cfg(1, 2, 3, 1, 2);
    for (int p = 0; p < 8; p++) send_beat(9, 0, p, p == 0, p == 7);
    for (int p = 0; p < 2; p++) send_beat(9, 1, p, 0, 0);
    set_cfg(1, 0, 2, 0, 1);            // takes effect only at the next SOF
    for (int p = 2; p < 8; p++) send_beat(9, 1, p, 0, p == 7);
    send_frame(10, 8, 2, 1);           // SOF where line 2 of frame 9 would start
    idle(5);
    exp_q.push_back(mk(9, 1, 2, 1, 0));
    exp_q.push_back(mk(9, 1, 3, 0, 0));
    exp_q.push_back(mk(9, 1, 4, 0, 1));
    exp_q.push_back(mk(10, 0, 0, 1, 0));
    exp_q.push_back(mk(10, 0, 1, 0, 1));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL midcfg_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL midcfg_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    got_q.delete(); exp_q.delete();
    set_cfg(1, 2, 3, 1, 2);
    for (int p = 0; p < 8; p++) send_beat(11, 0, p, p == 0, p == 7);
    for (int p = 0; p < 4; p++) send_beat(11, 1, p, 0, 0);
    // px3 now sits in the output register; reset must discard it
    i_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_tvalid, o_tuser, o_tlast, o_tdata} !== 19'd0) begin
      n_err++; $display("FAIL rst_outputs: got %h want 0", {o_tvalid, o_tuser, o_tlast, o_tdata});
    end
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_err++; $display("FAIL rst_state: got %b want 0", dbg_state);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int p = 4; p < 8; p++) send_beat(11, 1, p, 0, p == 7);
    for (int l = 2; l < 4; l++)
      for (int p = 0; p < 8; p++) send_beat(11, l, p, 0, p == 7);
    send_frame(12, 8, 4, 1);
    idle(5);
    exp_q.push_back(mk(11, 1, 2, 1, 0));
    push_case1(12);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rst_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rst_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    #1 rst_n = 1'b1;
    idle(2);
    test_crop();
    test_bypass();
    test_back_to_back_stall();
    test_pre_sof();
    test_edge_window();
    test_mid_frame_cfg();
    test_mid_frame_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
